hovalaag_io_port: RTL and testbench

Host-side endpoint of the Hovalaag CPU stream interface. It buffers two host-written input streams and presents their head words on IN1/IN2, popping on IN1_adv/IN2_adv. It also captures CPU OUT words qualified by OUT_valid into one of two output queues chosen by OUT_select, which the host drains with valid/ready handshakes. It sits between the CPU core and the test harness or host bus, and is the responder for every CPU I/O strobe.

---
 rtl/hovalaag_io_pkg.sv | 23 ++
 rtl/hovalaag_stream_fifo.sv | 74 +++++++
 rtl/hovalaag_io_port.sv | 119 +++++++++++
 tb/tb_hovalaag_io_port.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hovalaag_io_pkg.sv
// rtl/hovalaag_io_pkg.sv - shared constants and helpers for the Hovalaag I/O port
// Holds the default data width and queue depth, the output-queue select codes,
// and the pointer-width helper used to size queue pointers and counts.
package hovalaag_io_pkg;

    localparam int W_DEFAULT     = 12;
    localparam int DEPTH_DEFAULT = 16;

    // OUT_select encoding
    localparam logic SEL_OUT1 = 1'b0;
    localparam logic SEL_OUT2 = 1'b1;

    // Ceiling log2, evaluated at elaboration to size pointers.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hovalaag_stream_fifo.sv
// rtl/hovalaag_stream_fifo.sv - single-clock circular queue used for every Hovalaag stream
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   push, push_data    write request and word
//   pop                remove the head (no-op when empty)
//   head               word at the read pointer, 0 when empty
//   empty, full        occupancy status
//   pop_err            high in any cycle where pop is requested on an empty queue
module hovalaag_stream_fifo
    import hovalaag_io_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full,
    output logic         pop_err
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    logic do_pop;
    logic do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees a slot, so a push onto a full queue still lands.
    assign do_push = push && (!full || do_pop);
    assign pop_err = pop && empty;

    assign head = empty ? '0 : mem[rd_ptr];

    // Storage is deliberately not reset; every read is masked by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hovalaag_io_port.sv
// rtl/hovalaag_io_port.sv - host-side endpoint of the Hovalaag CPU stream interface
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in1_*/in2_*                   host push side of the two input queues
//   IN1/IN2, IN1_adv/IN2_adv      CPU view of the input heads and their pop strobes
//   OUT, OUT_valid, OUT_select    CPU output word capture and queue select
//   out1_*/out2_*                 host drain side of the two output queues
//   underflow, overflow           sticky error flags, bit 0 = queue 1, bit 1 = queue 2
//   clr_flags                     synchronous clear of both flag registers
module hovalaag_io_port
    import hovalaag_io_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int W     = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in1_data,
    input  logic [W-1:0] in2_data,
    input  logic         in1_valid,
    input  logic         in2_valid,
    output logic         in1_ready,
    output logic         in2_ready,
    output logic [W-1:0] IN1,
    output logic [W-1:0] IN2,
    input  logic         IN1_adv,
    input  logic         IN2_adv,
    input  logic [W-1:0] OUT,
    input  logic         OUT_valid,
    input  logic         OUT_select,
    output logic [W-1:0] out1_data,
    output logic [W-1:0] out2_data,
    output logic         out1_valid,
    output logic         out2_valid,
    input  logic         out1_ready,
    input  logic         out2_ready,
    output logic [1:0]   underflow,
    output logic [1:0]   overflow,
    input  logic         clr_flags
);

    logic in1_full, in2_full;
    logic in1_empty, in2_empty;
    logic in1_pop_err, in2_pop_err;
    logic in1_push, in2_push;

    logic out1_full, out2_full;
    logic out1_empty, out2_empty;
    logic out1_pop, out2_pop;
    logic cap1, cap2;

    // Output pops are already gated by valid, so their pop_err can never fire.
    logic [1:0] unused_out_pop_err;
    logic unused_in_empty;

    logic [1:0] underflow_set;
    logic [1:0] overflow_set;

    // Input side: ready reflects only fullness, a same-cycle CPU pop is ignored.
    assign in1_ready = !in1_full;
    assign in2_ready = !in2_full;
    assign in1_push  = in1_valid && in1_ready;
    assign in2_push  = in2_valid && in2_ready;
    assign unused_in_empty = in1_empty ^ in2_empty;

    // Output side: OUT_select demux and host handshake.
    assign cap1       = OUT_valid && (OUT_select == SEL_OUT1);
    assign cap2       = OUT_valid && (OUT_select == SEL_OUT2);
    assign out1_valid = !out1_empty;
    assign out2_valid = !out2_empty;
    assign out1_pop   = out1_ready && out1_valid;
    assign out2_pop   = out2_ready && out2_valid;

    hovalaag_stream_fifo #(.W(W), .DEPTH(DEPTH)) u_in1 (
        .clk(clk), .rst(rst),
        .push(in1_push), .push_data(in1_data), .pop(IN1_adv),
        .head(IN1), .empty(in1_empty), .full(in1_full), .pop_err(in1_pop_err)
    );

    hovalaag_stream_fifo #(.W(W), .DEPTH(DEPTH)) u_in2 (
        .clk(clk), .rst(rst),
        .push(in2_push), .push_data(in2_data), .pop(IN2_adv),
        .head(IN2), .empty(in2_empty), .full(in2_full), .pop_err(in2_pop_err)
    );

    hovalaag_stream_fifo #(.W(W), .DEPTH(DEPTH)) u_out1 (
        .clk(clk), .rst(rst),
        .push(cap1), .push_data(OUT), .pop(out1_pop),
        .head(out1_data), .empty(out1_empty), .full(out1_full),
        .pop_err(unused_out_pop_err[0])
    );

    hovalaag_stream_fifo #(.W(W), .DEPTH(DEPTH)) u_out2 (
        .clk(clk), .rst(rst),
        .push(cap2), .push_data(OUT), .pop(out2_pop),
        .head(out2_data), .empty(out2_empty), .full(out2_full),
        .pop_err(unused_out_pop_err[1])
    );

    // A capture is dropped only when the queue is full and not draining this cycle.
    assign underflow_set = {in2_pop_err, in1_pop_err};
    assign overflow_set  = {cap2 && out2_full && !out2_pop,
                            cap1 && out1_full && !out1_pop};

    // Sticky flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= '0;
            overflow  <= '0;
        end else if (clr_flags) begin
            underflow <= '0;
            overflow  <= '0;
        end else begin
            underflow <= underflow | underflow_set;
            overflow  <= overflow | overflow_set;
        end
    end

endmodule

// File: tb/tb_hovalaag_io_port.sv
// tb/tb_hovalaag_io_port.sv - self-checking bench for hovalaag_io_port
module tb_hovalaag_io_port;

    localparam int W     = 12;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in1_data, in2_data;
    logic          in1_valid, in2_valid;
    logic          in1_ready, in2_ready;
    logic [W-1:0]  IN1, IN2;
    logic          IN1_adv, IN2_adv;
    logic [W-1:0]  OUT;
    logic          OUT_valid, OUT_select;
    logic [W-1:0]  out1_data, out2_data;
    logic          out1_valid, out2_valid;
    logic          out1_ready, out2_ready;
    logic [1:0]    underflow, overflow;
    logic          clr_flags;

    hovalaag_io_port #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in1_data(in1_data), .in2_data(in2_data),
        .in1_valid(in1_valid), .in2_valid(in2_valid),
        .in1_ready(in1_ready), .in2_ready(in2_ready),
        .IN1(IN1), .IN2(IN2),
        .IN1_adv(IN1_adv), .IN2_adv(IN2_adv),
        .OUT(OUT), .OUT_valid(OUT_valid), .OUT_select(OUT_select),
        .out1_data(out1_data), .out2_data(out2_data),
        .out1_valid(out1_valid), .out2_valid(out2_valid),
        .out1_ready(out1_ready), .out2_ready(out2_ready),
        .underflow(underflow), .overflow(overflow),
        .clr_flags(clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         i1v;
        logic [W-1:0] i1d;
        logic         i2v;
        logic [W-1:0] i2d;
        logic         i1a;
        logic         i2a;
        logic         ov;
        logic [W-1:0] ow;
        logic         os;
        logic         o1r;
        logic         o2r;
        logic         clr;
    } in_t;

    typedef struct {
        logic         i1v;
        logic [W-1:0] i1d;
        logic         i1a;
        logic         i2a;
        logic         ov;
        logic [W-1:0] ow;
        logic         os;
        logic         clr;
        logic [W-1:0] e_in1;
        logic         e_rdy1;
        logic [W-1:0] e_o1;
        logic         e_o1v;
        logic [W-1:0] e_o2;
        logic         e_o2v;
        logic [1:0]   e_uf;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0=in1, 1=in2, 2=out1, 3=out2, kept as plain queues.
    logic [W-1:0] mq [4][$];
    logic [1:0]   m_uf, m_of;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mhead(input int n);
        if (mq[n].size() == 0) return '0;
        return mq[n][0];
    endfunction

    function automatic in_t idle();
        in_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) mq[n].delete();
        m_uf = '0;
        m_of = '0;
    endtask

    task automatic model_step(input in_t s);
        logic [1:0] uf_set, of_set;
        logic adv, v, rdy, cap, can_push;
        logic [W-1:0] d;
        uf_set = '0;
        of_set = '0;
        for (int n = 0; n < 2; n++) begin
            adv = (n == 0) ? s.i1a : s.i2a;
            v   = (n == 0) ? s.i1v : s.i2v;
            d   = (n == 0) ? s.i1d : s.i2d;
            can_push = (mq[n].size() < DEPTH);
            if (adv) begin
                if (mq[n].size() == 0) uf_set[n] = 1'b1;
                else void'(mq[n].pop_front());
            end
            if (v && can_push) mq[n].push_back(d);
        end
        for (int n = 0; n < 2; n++) begin
            rdy = (n == 0) ? s.o1r : s.o2r;
            if (rdy && mq[2+n].size() > 0) void'(mq[2+n].pop_front());
            cap = s.ov && (s.os == n[0]);
            if (cap) begin
                if (mq[2+n].size() < DEPTH) mq[2+n].push_back(s.ow);
                else of_set[n] = 1'b1;
            end
        end
        if (s.clr) begin
            m_uf = '0;
            m_of = '0;
        end else begin
            m_uf = m_uf | uf_set;
            m_of = m_of | of_set;
        end
    endtask

    task automatic check_model();
        chk("IN1", IN1, mhead(0));
        chk("IN2", IN2, mhead(1));
        chk("in1_ready", in1_ready, mq[0].size() < DEPTH);
        chk("in2_ready", in2_ready, mq[1].size() < DEPTH);
        chk("out1_data", out1_data, mhead(2));
        chk("out2_data", out2_data, mhead(3));
        chk("out1_valid", out1_valid, mq[2].size() > 0);
        chk("out2_valid", out2_valid, mq[3].size() > 0);
        chk("underflow", underflow, m_uf);
        chk("overflow", overflow, m_of);
    endtask

    // Drive one cycle of inputs, step the model, clock, then compare after the edge.
    task automatic apply(input in_t s);
        in1_valid = s.i1v; in1_data = s.i1d;
        in2_valid = s.i2v; in2_data = s.i2d;
        IN1_adv = s.i1a; IN2_adv = s.i2a;
        OUT_valid = s.ov; OUT = s.ow; OUT_select = s.os;
        out1_ready = s.o1r; out2_ready = s.o2r;
        clr_flags = s.clr;
        model_step(s);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive_idle();
        in1_valid = 0; in1_data = '0; in2_valid = 0; in2_data = '0;
        IN1_adv = 0; IN2_adv = 0; OUT_valid = 0; OUT = '0; OUT_select = 0;
        out1_ready = 0; out2_ready = 0; clr_flags = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tab [13];
    in_t  s;

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_IN1", IN1, 0);
        chk("rst_IN2", IN2, 0);
        chk("rst_out1_data", out1_data, 0);
        chk("rst_out2_data", out2_data, 0);
        chk("rst_out1_valid", out1_valid, 0);
        chk("rst_out2_valid", out2_valid, 0);
        chk("rst_in1_ready", in1_ready, 1);
        chk("rst_in2_ready", in2_ready, 1);
        chk("rst_underflow", underflow, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        //           i1v i1d     i1a i2a ov ow      os clr  e_in1   rdy e_o1    o1v e_o2    o2v uf
        tab[0]  = '{1, 12'h123, 0, 0, 0, 12'h000, 0, 0,  12'h123, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[1]  = '{1, 12'h456, 0, 0, 0, 12'h000, 0, 0,  12'h123, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[2]  = '{1, 12'hABC, 0, 0, 0, 12'h000, 0, 0,  12'h123, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[3]  = '{0, 12'h000, 1, 0, 0, 12'h000, 0, 0,  12'h456, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[4]  = '{0, 12'h000, 1, 0, 0, 12'h000, 0, 0,  12'hABC, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[5]  = '{0, 12'h000, 1, 0, 0, 12'h000, 0, 0,  12'h000, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[6]  = '{0, 12'h000, 0, 1, 0, 12'h000, 0, 0,  12'h000, 1, 12'h000, 0, 12'h000, 0, 2'b10};
        tab[7]  = '{0, 12'h000, 0, 0, 0, 12'h000, 0, 1,  12'h000, 1, 12'h000, 0, 12'h000, 0, 2'b00};
        tab[8]  = '{0, 12'h000, 0, 0, 1, 12'h0FF, 0, 0,  12'h000, 1, 12'h0FF, 1, 12'h000, 0, 2'b00};
        tab[9]  = '{0, 12'h000, 0, 0, 1, 12'h800, 1, 0,  12'h000, 1, 12'h0FF, 1, 12'h800, 1, 2'b00};
        // underflow pop with a same-cycle push and clear: clear wins, pushed word becomes head
        tab[10] = '{1, 12'h777, 1, 0, 0, 12'h000, 0, 1,  12'h777, 1, 12'h0FF, 1, 12'h800, 1, 2'b00};
        tab[11] = '{0, 12'h000, 1, 0, 0, 12'h000, 0, 0,  12'h000, 1, 12'h0FF, 1, 12'h800, 1, 2'b00};
        tab[12] = '{0, 12'h000, 1, 0, 0, 12'h000, 0, 0,  12'h000, 1, 12'h0FF, 1, 12'h800, 1, 2'b01};

        for (int k = 0; k < 13; k++) begin
            s = idle();
            s.i1v = tab[k].i1v; s.i1d = tab[k].i1d;
            s.i1a = tab[k].i1a; s.i2a = tab[k].i2a;
            s.ov = tab[k].ov; s.ow = tab[k].ow; s.os = tab[k].os;
            s.clr = tab[k].clr;
            apply(s);
            chk($sformatf("tab%0d_IN1", k), IN1, tab[k].e_in1);
            chk($sformatf("tab%0d_in1_ready", k), in1_ready, tab[k].e_rdy1);
            chk($sformatf("tab%0d_out1_data", k), out1_data, tab[k].e_o1);
            chk($sformatf("tab%0d_out1_valid", k), out1_valid, tab[k].e_o1v);
            chk($sformatf("tab%0d_out2_data", k), out2_data, tab[k].e_o2);
            chk($sformatf("tab%0d_out2_valid", k), out2_valid, tab[k].e_o2v);
            chk($sformatf("tab%0d_underflow", k), underflow, tab[k].e_uf);
        end

        // Asynchronous reset with three words queued in in1 and data in both outputs.
        for (int k = 0; k < 3; k++) begin
            s = idle(); s.i1v = 1; s.i1d = 12'(k + 1); s.clr = (k == 0);
            apply(s);
        end
        drive_idle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_IN1", IN1, 0);
        chk("async_in1_ready", in1_ready, 1);
        chk("async_out1_valid", out1_valid, 0);
        chk("async_out2_valid", out2_valid, 0);
        chk("async_out1_data", out1_data, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill out1 with 17 captures; the last is dropped.
        for (int i = 0; i < 17; i++) begin
            s = idle(); s.ov = 1; s.ow = 12'(i); s.os = 0;
            apply(s);
        end
        chk("ovf_bit", overflow, 2'b01);
        chk("ovf_head", out1_data, 0);
        s = idle(); s.clr = 1;
        apply(s);
        // Capture on a full queue while the host pops: space frees, no overflow.
        s = idle(); s.ov = 1; s.ow = 12'h555; s.os = 0; s.o1r = 1;
        apply(s);
        chk("cap_with_pop_ovf", overflow, 2'b00);
        for (int i = 0; i < 16; i++) begin
            chk("drain", out1_data, (i < 15) ? (i + 1) : 12'h555);
            s = idle(); s.o1r = 1;
            apply(s);
        end
        chk("drain_empty", out1_valid, 0);

        // Wrap and concurrency on in1.
        do_reset();
        s = idle(); s.i1v = 1; s.i1d = 12'h001;
        apply(s);
        for (int i = 0; i < 40; i++) begin
            s = idle(); s.i1v = 1; s.i1d = 12'(i + 2); s.i1a = 1;
            apply(s);
            chk("wrap_IN1", IN1, i + 2);
            chk("wrap_ready", in1_ready, 1);
        end

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            s = idle();
            s.i1v = ($urandom_range(0, 99) < 75);
            s.i2v = ($urandom_range(0, 99) < 75);
            s.i1d = 12'($urandom);
            s.i2d = 12'($urandom);
            s.i1a = ($urandom_range(0, 99) < ((c < 400) ? 35 : 85));
            s.i2a = ($urandom_range(0, 99) < ((c < 400) ? 35 : 85));
            s.ov  = ($urandom_range(0, 99) < 60);
            s.ow  = 12'($urandom);
            s.os  = 1'($urandom);
            s.o1r = ($urandom_range(0, 99) < ((c < 400) ? 20 : 80));
            s.o2r = ($urandom_range(0, 99) < ((c < 400) ? 20 : 80));
            s.clr = ($urandom_range(0, 99) < 4);
            apply(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
